// File: rtl/mio_bus_ctrl_if.sv
// CPU-side request/done signals and MIO bus signals for one mio_bus_ctrl.
// Handshake: the controller samples cpu_req only in IDLE, answers with a one-cycle cpu_done; MIO_ready is only honoured while mio_cs is high.
interface mio_bus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [DATA_W/8-1:0]   cpu_be;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_done;
    logic                  cpu_err;
    logic                  cpu_busy;
    logic                  mio_cs;
    logic                  mio_w;
    logic [ADDR_W-1:0]     mio_addr;
    logic [DATA_W-1:0]     mio_wdata;
    logic [DATA_W/8-1:0]   mio_be;
    logic [DATA_W-1:0]     mio_rdata;
    logic                  MIO_ready;

    // The controller masters the MIO bus and serves the CPU.
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mio_rdata, MIO_ready,
        output cpu_rdata, cpu_done, cpu_err, cpu_busy,
        output mio_cs, mio_w, mio_addr, mio_wdata, mio_be
    );

    // CPU core plus bus decoder view.
    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mio_rdata, MIO_ready,
        input  cpu_rdata, cpu_done, cpu_err, cpu_busy,
        input  mio_cs, mio_w, mio_addr, mio_wdata, mio_be
    );
endinterface

// File: rtl/mio_bus_ctrl.sv
// Memory/IO access sequencer: one registered CPU request at a time onto the MIO bus,
// with an optional wait-state timeout that completes the access with an error flag.
module mio_bus_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    mio_bus_ctrl_if.master bus,
    output logic [1:0] state_dbg
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;

    logic accept;
    logic ready_hit;
    logic timeout_hit;

    assign accept      = (state_q == S_IDLE) && bus.cpu_req;
    assign ready_hit   = (state_q == S_WAIT) && bus.MIO_ready;
    // Bus completion wins over a timeout landing on the same edge.
    assign timeout_hit = (state_q == S_WAIT) && !bus.MIO_ready &&
                         (TIMEOUT != 0) && (cnt_q == TO_VAL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_WAIT;
            S_WAIT:  if (ready_hit || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.cpu_we;
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
                be_q    <= bus.cpu_be;
                cnt_q   <= '0;
            end else if (ready_hit) begin
                err_q <= 1'b0;
                if (!we_q) rdata_q <= bus.mio_rdata;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
                if (!we_q) rdata_q <= '1;
            end else if (state_q == S_WAIT && cnt_q != '1) begin
                // Saturating so a disabled timeout never wraps the counter.
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Bus strobes come straight from state so an asynchronous reset drops them at once.
    assign bus.mio_cs    = (state_q == S_WAIT);
    assign bus.mio_w     = (state_q == S_WAIT) && we_q;
    assign bus.mio_wdata = ((state_q == S_WAIT) && we_q) ? wdata_q : '0;
    assign bus.mio_addr  = addr_q;
    assign bus.mio_be    = be_q;

    assign bus.cpu_done  = (state_q == S_DONE);
    assign bus.cpu_err   = (state_q == S_DONE) && err_q;
    assign bus.cpu_busy  = (state_q != S_IDLE);
    assign bus.cpu_rdata = rdata_q;

    assign state_dbg = state_q;
endmodule
